// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin grant arbiter.
// Holds state encodings, requester count and the rotating-priority search.
package rr_grant_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    // Returns {found, index}: first set request scanning ptr+1 .. ptr+4 (mod 4).
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] cand;
        rr_pick = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ptr + ID_W'(i);
            if (req[cand]) begin
                rr_pick = {1'b1, cand};
            end
        end
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_decoder.sv
// 2-to-4 enable decoder turning the registered owner index into a one-hot grant.
// Purely combinational; output is all-zero when en is low.
module grant_decoder
    import rr_grant_arbiter_pkg::*;
(
    input  logic [ID_W-1:0]    addr,
    input  logic               en,
    output logic [NUM_REQ-1:0] dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin arbiter with hold limit and one dead cycle between owners.
// Grant visible one cycle after the request is sampled; all outputs come from registers.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [7:0]      hold_cnt;
    logic [ID_W:0]   pick;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic            owner_req;
    logic            other_req;

    assign pick      = rr_pick(req, ptr);
    assign win_found = pick[ID_W];
    assign win_id    = pick[ID_W-1:0];

    // gnt is the owner mask while granting, so it splits req into owner/others.
    assign owner_req = |(req & gnt);
    assign other_req = |(req & ~gnt);

    grant_decoder u_dec (
        .addr (gnt_id),
        .en   (gnt_valid),
        .dec  (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE, TURNAROUND: begin
                    if (win_found) begin
                        state     <= GRANT;
                        ptr       <= win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        busy      <= 1'b1;
                        hold_cnt  <= 8'd1;
                    end else begin
                        state     <= IDLE;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        busy      <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || (hold_cnt >= HOLD_LIM && other_req)) begin
                        state     <= TURNAROUND;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (hold_cnt < HOLD_LIM) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    busy      <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Four-way round-robin arbiter that shares a single one-hot-selected resource among four requesters. Each cycle it picks at most one owner, holds the grant while the owner keeps requesting (bounded by a hold limit), and inserts one dead cycle between owners. The grant index is expanded to a one-hot grant vector by a 2-to-4 enable decoder. Sits between requesting masters and the shared resource's select lines.

## Interface
- `HOLD_MAX`, 8: maximum consecutive GRANT cycles for one owner while another requester is pending; legal range 1..255.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  4  level request per requester; bit i = requester i.
- `gnt`  out  4  one-hot grant; all zero when no owner.
- `gnt_valid`  out  1  high when `gnt` is non-zero.
- `gnt_id`  out  2  index of current owner; 0 when `gnt_valid` is low.
- `busy`  out  1  high in GRANT or TURNAROUND.

## Operation
- Reset values: state = IDLE; `gnt` = 4'b0000; `gnt_valid` = 0; `gnt_id` = 0; `busy` = 0; last-winner pointer `ptr` = 3, so requester 0 has top priority first; hold counter = 0.
- States:
  - IDLE: if any `req` bit is high, pick the winner and go to GRANT; otherwise stay.
  - GRANT: owner `gnt_id` is driven.
    - Owner's `req` low: go to TURNAROUND.
    - Hold counter reaches `HOLD_MAX` and any other `req` bit is high: go to TURNAROUND.
    - Otherwise stay. The counter increments each GRANT cycle and saturates at `HOLD_MAX`.
  - TURNAROUND: exactly one cycle with `gnt` = 0. Then re-arbitrate as in IDLE: a winner goes directly to GRANT, no requests go to IDLE.
- Winner selection: scan `ptr+1`, `ptr+2`, `ptr+3`, `ptr+4` (mod 4) and take the first set `req` bit.
  - On entry to GRANT: `ptr` ← winner; hold counter ← 1.
  - A timed-out owner that is the only requester after TURNAROUND wins again.
- `gnt` = decode(`gnt_id`) gated by `gnt_valid`. It is always one-hot or zero; never more than one bit.
- Hold counter width is 8 bits. Comparison is `count >= HOLD_MAX`.
- `req` changes from non-owners during GRANT have no effect on `gnt`.

## Timing
- All outputs are registered; no combinational path from `req` to `gnt`.
- Latency: `req` sampled high at edge N (from IDLE) → `gnt` high after edge N, visible in cycle N+1.
- Owner drops `req` in cycle K → `gnt` low from edge K+1 (TURNAROUND), next owner from edge K+2.
- Minimum handover gap between two owners: 1 cycle of all-zero `gnt`.
- Timeout: the owner holds for exactly `HOLD_MAX` cycles, then 1 TURNAROUND cycle, then the next winner.
- Simultaneous owner `req` drop and timeout: treated as a drop. The result is the same TURNAROUND.
- Reset asserted mid-GRANT: `gnt` goes to 0 asynchronously and `ptr` returns to 3. After `reset` deasserts, the first arbitration edge behaves as from power-up.

## Structure
- Shared package/header holds:
  - state encodings: IDLE = 2'd0, GRANT = 2'd1, TURNAROUND = 2'd2;
  - `NUM_REQ` = 4;
  - `ID_W` = 2.
- One sub-module, `grant_decoder`: 2-bit address plus enable in, 4 one-hot outputs out, purely combinational. It is instantiated once to produce `gnt` from the `gnt_id`/`gnt_valid` registers.
- Top level contains:
  - state register;
  - `ptr` and `gnt_id` registers;
  - hold counter;
  - rotate-priority search logic.

## Test plan
- Reset, then `req` = 4'b0000 for 5 cycles → `gnt` = 0, `busy` = 0, state stays IDLE.
- After reset, `req` = 4'b1111 held, `HOLD_MAX` = 2 → owners 0,1,2,3,0 in order. Each owner has 2 GRANT cycles followed by 1 all-zero cycle.
- `req` = 4'b0100 for 3 cycles then 0 → `gnt` = 4'b0100 starting 1 cycle after `req`, for 3 cycles; then 1 TURNAROUND cycle; then IDLE.
- Owner 1 granted, `req[1]` drops in the same cycle the counter hits `HOLD_MAX` while `req[3]` is high → a single zero cycle, then `gnt` = 4'b1000.
- `req` = 4'b0010 only, `HOLD_MAX` = 3, held 10 cycles:
  - TURNAROUND after 3 GRANT cycles only if another `req` is pending;
  - with none pending, `gnt` = 4'b0010 is continuous for all 10 cycles.
- `reset` pulsed mid-GRANT of owner 2 → `gnt` = 0 immediately. With `req` = 4'b0101 after release, owner 0 is granted first.
